// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequential nibble-CLA add/sub unit.
// CLA_SEQ_SAT_EN (optional) enables result saturation on signed overflow.
package cla_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NIB   = DEF_WIDTH / 4;
   localparam int NIB_IDX_W = $clog2(DEF_NIB);

   // Most positive (sign=0) or most negative (sign=1) value of a width-bit word.
   function automatic logic [63:0] sat_val(input logic sign, input int width);
      logic [63:0] msb;
      msb = 64'd1 << (width - 1);
      return sign ? msb : msb - 64'd1;
   endfunction

endpackage

// File: rtl/CLA_adder_4.sv
// 4-bit carry-lookahead slice with signed-overflow flag and group generate/propagate.
module CLA_adder_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       ovfl,
   output logic       tg,
   output logic       tp
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = tg | (tp & c[0]);

   assign tg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign tp = &p;

   assign sum  = p ^ c[3:0];
   assign cout = c[4];
   // Carry into and out of the top bit disagree exactly on two's-complement overflow.
   assign ovfl = c[3] ^ c[4];

endmodule

// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit add/sub walking one shared 4-bit CLA slice from LSB to MSB nibble.
// Optional macro CLA_SEQ_SAT_EN saturates the result on signed overflow.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one nibble per cycle through the slice, carry registered between steps
// DONE  | result held until out_ready
module cla_nibble_seq
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovfl
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = $clog2(NIB);

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovfl_q;
   logic [IDX_W-1:0] idx;
   logic [IDX_W+1:0] bit_pos;

   logic [3:0] slice_sum;
   logic       slice_cout;
   logic       slice_ovfl;
   logic       unused_tg;
   logic       unused_tp;
   logic       accept;
   logic       last;

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (state == RUN) && (idx == IDX_W'(NIB - 1));
   assign bit_pos   = {idx, 2'b00};

   CLA_adder_4 u_slice (
      .a    (a_q[bit_pos +: 4]),
      .b    (b_q[bit_pos +: 4]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .ovfl (slice_ovfl),
      .tg   (unused_tg),
      .tp   (unused_tp)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)    state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovfl_q  <= 1'b0;
         idx     <= '0;
      end else if (accept) begin
         // Subtraction as A + ~B + 1: the +1 rides in on the first carry.
         a_q     <= op_a;
         b_q     <= sub ? ~op_b : op_b;
         carry_q <= sub;
         idx     <= '0;
      end else if (state == RUN) begin
         res_q[bit_pos +: 4] <= slice_sum;
         carry_q             <= slice_cout;
         idx                 <= idx + 1'b1;
         if (last) begin
            cout_q <= slice_cout;
            ovfl_q <= slice_ovfl;
         end
      end
   end

`ifdef CLA_SEQ_SAT_EN
   assign result = ovfl_q ? WIDTH'(sat_val(a_q[WIDTH-1], WIDTH)) : res_q;
`else
   assign result = res_q;
`endif
   assign cout = cout_q;
   assign ovfl = ovfl_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq (WIDTH=16) with an arithmetic reference model.
module tb_cla_nibble_seq;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         cout;
   logic         ovfl;

   int checks = 0;
   int errors = 0;

   cla_nibble_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovfl      (ovfl)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 busy counting cycles, 2 result pending.
   bit           m_on = 1'b0;
   bit           m_fresh = 1'b0;
   int           m_phase = 0;
   int           m_left = 0;
   int           m_sum = 0;
   logic [W-1:0] m_res = '0;
   logic         m_cout = 1'b0;
   logic         m_ovfl = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_on    = 1'b1;
         m_fresh = 1'b1;
         m_phase = 0;
      end else if (m_on) begin
         case (m_phase)
            0: if (in_valid) begin
               m_sum   = sub ? int'($signed(op_a)) - int'($signed(op_b))
                             : int'($signed(op_a)) + int'($signed(op_b));
               m_ovfl  = (m_sum > 32767) || (m_sum < -32768);
               m_cout  = sub ? (op_a >= op_b) : ((int'(op_a) + int'(op_b)) > 65535);
               m_res   = sub ? op_a - op_b : op_a + op_b;
`ifdef CLA_SEQ_SAT_EN
               if (m_ovfl) m_res = op_a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
               m_left  = NIB;
               m_phase = 1;
               m_fresh = 1'b0;
            end
            1: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0) && !rst});
         check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
         if (m_phase == 2) begin
            check("result", {16'd0, result}, {16'd0, m_res});
            check("cout", {31'd0, cout}, {31'd0, m_cout});
            check("ovfl", {31'd0, ovfl}, {31'd0, m_ovfl});
         end else if (m_fresh) begin
            check("reset_result", {16'd0, result}, 32'd0);
            check("reset_flags", {30'd0, cout, ovfl}, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int wait_cnt;
      op_a = a;
      op_b = b;
      sub = s;
      in_valid = 1'b1;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
         step();
         wait_cnt++;
      end
      if (wait_cnt >= 20) check("in_ready_timeout", 32'd1, 32'd0);
      step();
      in_valid = 1'b0;
      // Operands must only matter at the accept edge.
      op_a = ~a;
      op_b = a ^ b;
      sub = ~s;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input int hold, input bit try_new);
      int lat;
      start_op(a, b, s);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("latency", lat, NIB);
      check("lit_result", {16'd0, result}, {16'd0, er});
      check("lit_cout", {31'd0, cout}, {31'd0, ec});
      check("lit_ovfl", {31'd0, ovfl}, {31'd0, eo});
      if (try_new) begin
         op_a = 16'h1111;
         op_b = 16'h2222;
         in_valid = 1'b1;
      end
      repeat (hold) step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("idle_after_accept", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      step();

      run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 0, 1'b0);
      run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 2, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
`ifdef CLA_SEQ_SAT_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 0, 1'b0);
      run_op(16'h9000, 16'h2000, 1'b1, 16'h8000, 1'b1, 1'b1, 5, 1'b1);
`else
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);
      run_op(16'h9000, 16'h2000, 1'b1, 16'h7000, 1'b1, 1'b1, 5, 1'b1);
`endif
      run_op(16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 1'b1);

      // Abort an operation two cycles into RUN.
      start_op(16'h1234, 16'h4321, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result", {16'd0, result}, 32'd0);
      step();
      run_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout reached");
      $fatal(1);
   end

endmodule
